// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// The arbiter top honours the optional `UART_ARB_LOCK_EN` packet-lock build macro.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD       = 2'd1,
        WAIT_BUSY  = 2'd2,
        WAIT_EMPTY = 2'd3
    } arb_state_t;

    localparam int UART_DATA_W = 8;

    function automatic int id_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: rotate the request vector so the pointer sits at bit 0,
// take the lowest set bit, then rotate the index back.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDW-1:0]     idx_o,
    output logic               any_o
);

    localparam logic [IDW:0] NUM_L = (IDW+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [IDW-1:0]       enc_s;
    logic [IDW:0]         sum_s;

    // rotate, priority-encode, rotate back
    always_comb begin
        dbl_s = {req_i, req_i} >> ptr_i;
        rot_s = dbl_s[NUM_REQ-1:0];
        enc_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                enc_s = k[IDW-1:0];
            end else begin
                enc_s = enc_s;
            end
        end
        sum_s = {1'b0, enc_s} + {1'b0, ptr_i};
        if (sum_s >= NUM_L) begin
            sum_s = sum_s - NUM_L;
        end else begin
            sum_s = sum_s;
        end
        any_o = |rot_s;
        idx_o = sum_s[IDW-1:0];
        gnt_o = {{(NUM_REQ-1){1'b0}}, any_o} << idx_o;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ producers.
// Build macro UART_ARB_LOCK_EN keeps a requester granted until its req_last byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = UART_DATA_W,
    parameter int TMO_CYCLES = 64
) (
    input  logic                        txclk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [id_width(NUM_REQ)-1:0] grant_id,
    output logic                        busy,
    output logic                        ld_tx_data,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_enable,
    input  logic                        tx_empty,
    output logic                        err_timeout,
    input  logic                        err_clr
);

    localparam int IDW = id_width(NUM_REQ);
    localparam int WDW = $clog2(TMO_CYCLES + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TMO_CYCLES - 1);
    localparam logic [WDW-1:0] WD_ONE = WDW'(1);
    localparam logic [IDW:0]   NUM_L  = (IDW+1)'(NUM_REQ);
    localparam logic [IDW:0]   ID_ONE = (IDW+1)'(1);

    arb_state_t          state_q;
    logic [IDW-1:0]      ptr_q;
    logic [DATA_W-1:0]   byte_q;
    logic [WDW-1:0]      wd_q;
    logic                wb_cnt_q;
    logic                reissue_q;
    logic [NUM_REQ-1:0]  req_ready_q;
    logic [IDW-1:0]      grant_id_q;
    logic                busy_q;
    logic                ld_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic                tx_en_q;
    logic                err_q;

    logic [NUM_REQ-1:0]  elig_s;
    logic [NUM_REQ-1:0]  gnt_s;
    logic [IDW-1:0]      win_idx_s;
    logic                any_s;
    logic [IDW:0]        inc_s;
    logic [IDW-1:0]      ptr_d;
    logic [DATA_W-1:0]   win_byte_s;

`ifdef UART_ARB_LOCK_EN
    logic                lock_q;
    logic [IDW-1:0]      lock_id_q;
    logic [NUM_REQ-1:0]  lock_mask_s;

    // while a packet is open only its owner may compete
    always_comb begin
        lock_mask_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << lock_id_q;
        if (lock_q) begin
            elig_s = req_valid & lock_mask_s;
        end else begin
            elig_s = req_valid;
        end
    end
`else
    logic unused_last_s;
    assign unused_last_s = ^req_last;

    // per-byte arbitration: every valid requester competes
    always_comb begin
        elig_s = req_valid;
    end
`endif

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req_i  (elig_s),
        .ptr_i  (ptr_q),
        .gnt_o  (gnt_s),
        .idx_o  (win_idx_s),
        .any_o  (any_s)
    );

    // next search start and the winning byte
    always_comb begin
        inc_s = {1'b0, win_idx_s} + ID_ONE;
        if (inc_s >= NUM_L) begin
            ptr_d = '0;
        end else begin
            ptr_d = inc_s[IDW-1:0];
        end
        win_byte_s = req_data[win_idx_s*DATA_W +: DATA_W];
    end

    // arbiter FSM with registered outputs; set of err_timeout wins over err_clr
    always_ff @(posedge txclk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            byte_q      <= '0;
            wd_q        <= '0;
            wb_cnt_q    <= 1'b0;
            reissue_q   <= 1'b0;
            req_ready_q <= '0;
            grant_id_q  <= '0;
            busy_q      <= 1'b0;
            ld_q        <= 1'b0;
            tx_data_q   <= '0;
            tx_en_q     <= 1'b0;
            err_q       <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock_q      <= 1'b0;
            lock_id_q   <= '0;
`endif
        end else begin
            req_ready_q <= '0;
            ld_q        <= 1'b0;
            tx_en_q     <= en;
            if (err_clr) begin
                err_q <= 1'b0;
            end else begin
                err_q <= err_q;
            end
            case (state_q)
                IDLE: begin
                    if (en && tx_empty && any_s) begin
                        req_ready_q <= gnt_s;
                        byte_q      <= win_byte_s;
                        grant_id_q  <= win_idx_s;
                        ptr_q       <= ptr_d;
                        reissue_q   <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= LOAD;
`ifdef UART_ARB_LOCK_EN
                        lock_q      <= ~req_last[win_idx_s];
                        lock_id_q   <= win_idx_s;
`endif
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                LOAD: begin
                    ld_q      <= 1'b1;
                    tx_data_q <= byte_q;
                    wb_cnt_q  <= 1'b0;
                    wd_q      <= '0;
                    if (reissue_q) begin
                        state_q <= WAIT_EMPTY;
                    end else begin
                        state_q <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (!tx_empty) begin
                        state_q <= WAIT_EMPTY;
                    end else if (wb_cnt_q) begin
                        // uart never went busy: load the same byte one more time
                        reissue_q <= 1'b1;
                        state_q   <= LOAD;
                    end else begin
                        wb_cnt_q <= 1'b1;
                    end
                end
                WAIT_EMPTY: begin
                    if (tx_empty) begin
                        wd_q    <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (en) begin
                        if (wd_q == WD_MAX) begin
                            err_q   <= 1'b1;
                            wd_q    <= '0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            wd_q <= wd_q + WD_ONE;
                        end
                    end else begin
                        wd_q <= wd_q;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign ld_tx_data  = ld_q;
    assign tx_data     = tx_data_q;
    assign tx_enable   = tx_en_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart frame-timer model.
// Expected grant orders follow the round-robin and packet-lock rules.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          txclk = 1'b0;
    logic          reset;
    logic          en;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic [1:0]    grant_id;
    logic          busy;
    logic          ld_tx_data;
    logic [DW-1:0] tx_data;
    logic          tx_enable;
    logic          tx_empty;
    logic          err_timeout;
    logic          err_clr;

    int passed = 0;
    int total  = 0;
    int frame_cycles = 10;
    int u_cnt = 0;
    int ld_cnt = 0;
    int rdy_cnt [N];
    int pkt_mode = 0;
    int pkt1 = 0;

    typedef struct {
        logic [N-1:0] mask;
        int           exp_id;
    } vec_t;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TMO_CYCLES(64)) dut (
        .txclk       (txclk),
        .reset       (reset),
        .en          (en),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .ld_tx_data  (ld_tx_data),
        .tx_data     (tx_data),
        .tx_enable   (tx_enable),
        .tx_empty    (tx_empty),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 txclk = ~txclk;

    // uart model: busy for frame_cycles shifting cycles after each load
    always @(posedge txclk) begin
        if (reset) begin
            u_cnt <= 0;
        end else if (ld_tx_data) begin
            u_cnt <= frame_cycles;
        end else if (u_cnt > 0 && tx_enable) begin
            u_cnt <= u_cnt - 1;
        end
    end
    assign tx_empty = (u_cnt == 0);

    always @(negedge txclk) begin
        if (ld_tx_data) ld_cnt <= ld_cnt + 1;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) rdy_cnt[i] <= rdy_cnt[i] + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge txclk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " req_ready"}, 32'(req_ready), 32'h0);
        check({tag, " grant_id"}, 32'(grant_id), 32'h0);
        check({tag, " busy"}, 32'(busy), 32'h0);
        check({tag, " ld_tx_data"}, 32'(ld_tx_data), 32'h0);
        check({tag, " tx_data"}, 32'(tx_data), 32'h0);
        check({tag, " tx_enable"}, 32'(tx_enable), 32'h0);
        check({tag, " err_timeout"}, 32'(err_timeout), 32'h0);
    endtask

    // present mask, expect the one-hot accept for exp, then the matching load
    task automatic do_grant(input logic [N-1:0] mask, input int exp, input string tag);
        int waited;
        logic [DW-1:0] exp_byte;
        req_valid = mask;
        waited = 0;
        while (req_ready == '0 && waited < 300) begin
            tick();
            waited++;
        end
        check({tag, " grant wait"}, 32'(waited < 300), 32'h1);
        check({tag, " req_ready"}, 32'(req_ready), 32'(4'b0001 << exp));
        check({tag, " grant_id"}, 32'(grant_id), 32'(exp));
        exp_byte = req_data[exp*DW +: DW];
        tick();
        req_data[exp*DW +: DW] = exp_byte + 8'd1;
        if (pkt_mode != 0 && exp == 1) begin
            pkt1++;
            req_last[1] = (pkt1 == 2);
        end
        check({tag, " ld_tx_data"}, 32'(ld_tx_data), 32'h1);
        check({tag, " tx_data"}, 32'(tx_data), 32'(exp_byte));
    endtask

    task automatic wait_idle(input string tag);
        int waited;
        waited = 0;
        while (!(busy == 1'b0 && tx_empty == 1'b1) && waited < 300) begin
            tick();
            waited++;
        end
        check({tag, " idle wait"}, 32'(waited < 300), 32'h1);
    endtask

    initial begin
        vec_t vecs [9];
        int   ld_snap;
        int   r1_snap;
        int   r3_snap;
        int   no_rdy;
        int   exp6 [4];

        vecs[0] = '{4'b1111, 0};
        vecs[1] = '{4'b1111, 1};
        vecs[2] = '{4'b1111, 2};
        vecs[3] = '{4'b1111, 3};
        vecs[4] = '{4'b1111, 0};
        vecs[5] = '{4'b0101, 2};
        vecs[6] = '{4'b0101, 0};
        vecs[7] = '{4'b0101, 2};
        vecs[8] = '{4'b0101, 0};
`ifdef UART_ARB_LOCK_EN
        exp6 = '{1, 1, 1, 0};
`else
        exp6 = '{1, 0, 1, 0};
`endif
        for (int i = 0; i < N; i++) begin
            rdy_cnt[i] = 0;
            req_data[i*DW +: DW] = {4'(i), 4'h0};
        end
        reset = 1'b1;
        en = 1'b1;
        req_valid = '0;
        req_last = 4'b1111;
        err_clr = 1'b0;
        repeat (3) tick();
        check_reset_state("reset");
        reset = 1'b0;

        // round-robin over all four, then alternating pair 2/0
        ld_snap = ld_cnt;
        r1_snap = 0;
        r3_snap = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 5) begin
                r1_snap = rdy_cnt[1];
                r3_snap = rdy_cnt[3];
            end
            do_grant(vecs[i].mask, vecs[i].exp_id, $sformatf("vec%0d", i));
        end
        check("pair no ready req1", 32'(rdy_cnt[1] - r1_snap), 32'h0);
        check("pair no ready req3", 32'(rdy_cnt[3] - r3_snap), 32'h0);
        req_valid = '0;
        wait_idle("table");
        check("one load per byte", 32'(ld_cnt - ld_snap), 32'd9);

        // watchdog: uart stays busy for 100 cycles
        frame_cycles = 100;
        do_grant(4'b0001, 0, "tmo");
        req_valid = '0;
        repeat (65) tick();
        check("tmo not yet", 32'(err_timeout), 32'h0);
        tick();
        check("tmo set", 32'(err_timeout), 32'h1);
        check("tmo idle", 32'(busy), 32'h0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("tmo cleared", 32'(err_timeout), 32'h0);
        frame_cycles = 10;
        wait_idle("tmo");

        // en=0 in flight: no grants, no error, frame resumes on en=1
        do_grant(4'b0010, 1, "en");
        req_valid = 4'b1111;
        repeat (3) tick();
        en = 1'b0;
        no_rdy = 1;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (req_ready != '0) no_rdy = 0;
        end
        check("en0 no ready", 32'(no_rdy), 32'h1);
        check("en0 tx_enable", 32'(tx_enable), 32'h0);
        check("en0 busy", 32'(busy), 32'h1);
        check("en0 no err", 32'(err_timeout), 32'h0);
        en = 1'b1;
        do_grant(4'b1111, 2, "en1");
        check("en1 no err", 32'(err_timeout), 32'h0);
        req_valid = '0;
        wait_idle("en1");

        // reset while the grant is being loaded
        req_valid = 4'b1111;
        no_rdy = 0;
        while (req_ready == '0 && no_rdy < 300) begin
            tick();
            no_rdy++;
        end
        check("rst grant", 32'(req_ready), 32'h8);
        reset = 1'b1;
        tick();
        check_reset_state("midrst");
        reset = 1'b0;
        do_grant(4'b1111, 0, "postrst");
        req_valid = '0;
        wait_idle("postrst");

        // packet from req1 competing with req0
        pkt_mode = 1;
        pkt1 = 0;
        req_last = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            do_grant(4'b0011, exp6[k], $sformatf("pkt%0d", k));
        end
        req_valid = '0;
        wait_idle("pkt");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
